// File: rtl/ahb_uvc_pkg.sv
// Shared AHB-Lite types for the AHB_UVC slave memory.
// Holds transfer enums, response constants and the slave FSM state type.
package ahb_uvc_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3,
        HSIZE_4W    = 3'd4,
        HSIZE_8W    = 3'd5,
        HSIZE_16W   = 3'd6,
        HSIZE_32W   = 3'd7
    } hsize_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERR1 = 2'd2,
        S_ERR2 = 2'd3
    } slv_state_e;

endpackage

// File: rtl/ahb_uvc_byte_lane_dec.sv
// Byte-lane decoder: low address bits + Hsize -> byte strobes and
// misalignment flag.
module ahb_uvc_byte_lane_dec #(
    parameter int DATA_WIDTH = 32,
    localparam int NB = DATA_WIDTH / 8,
    localparam int BW = $clog2(NB)
) (
    input  logic [BW-1:0] addr_i,
    input  logic [2:0]    size_i,
    output logic [NB-1:0] strb_o,
    output logic          align_err_o
);

    always_comb begin
        strb_o = '0;
        // A lane is selected when it shares the size-aligned block of addr.
        for (int i = 0; i < NB; i++) begin
            strb_o[i] = ((i >> size_i) == (int'(addr_i) >> size_i));
        end
        align_err_o = (int'(addr_i) & ((1 << size_i) - 1)) != 0;
    end

endmodule

// File: rtl/ahb_uvc_slave_mem.sv
// AHB-Lite slave memory with byte-lane writes, wait states,
// an error region and two-cycle ERROR responses.
module ahb_uvc_slave_mem
    import ahb_uvc_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0,
    parameter logic [ADDR_WIDTH-1:0] ERR_BASE = 'h0000_F000,
    parameter logic [ADDR_WIDTH-1:0] ERR_MASK = 'hFFFF_F000
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  Hsel,
    input  logic [ADDR_WIDTH-1:0] Haddr,
    input  logic [1:0]            Htrans,
    input  logic                  Hwrite,
    input  logic [2:0]            Hsize,
    input  logic [2:0]            Hburst,
    input  logic                  Hmastlock,
    input  logic [3:0]            Hprot,
    input  logic [DATA_WIDTH-1:0] Hwdata,
    input  logic                  Hready_in,
    output logic [DATA_WIDTH-1:0] Hrdata,
    output logic                  Hready_out,
    output logic                  Hresp
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int BW = $clog2(NB);
    localparam int IW = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [2:0] CNT_LOAD =
        (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    slv_state_e state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  dp_q, dp_d;
    logic                  wr_q, wr_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NB-1:0]         strb_q, strb_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic [NB-1:0]         strb;
    logic                  align_err;
    logic                  err, accept, ready, wr_en, fwd;
    logic [IW-1:0]         rd_idx;
    logic [DATA_WIDTH-1:0] wr_word, rd_word;
    logic                  unused_ok;

    assign unused_ok = ^{Hburst, Hmastlock, Hprot, Htrans[0]};

    ahb_uvc_byte_lane_dec #(.DATA_WIDTH(DATA_WIDTH)) u_dec (
        .addr_i      (Haddr[BW-1:0]),
        .size_i      (Hsize),
        .strb_o      (strb),
        .align_err_o (align_err)
    );

    assign ready  = (state_q != S_WAIT) && (state_q != S_ERR1);
    assign accept = Hsel && Hready_in && Htrans[1] && ready;
    assign err    = ((Haddr & ERR_MASK) == ERR_BASE)
                 || (Hsize > 3'(BW))
                 || align_err
                 || ((Haddr >> BW) >= DEPTH_A);

    // Final data cycle of a good transfer is IDLE with a pending phase.
    assign wr_en  = (state_q == S_IDLE) && dp_q && wr_q;
    assign rd_idx = Haddr[BW +: IW];
    assign fwd    = wr_en && (idx_q == rd_idx);

    always_comb begin
        wr_word = mem_q[idx_q];
        for (int b = 0; b < NB; b++) begin
            if (strb_q[b]) wr_word[8*b +: 8] = Hwdata[8*b +: 8];
        end
        rd_word = fwd ? wr_word : mem_q[rd_idx];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE, S_ERR2: begin
                state_d = S_IDLE;
                if (accept) begin
                    if (err) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) state_d = S_IDLE;
                else               cnt_d   = cnt_q - 3'd1;
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        dp_d    = dp_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        strb_d  = strb_q;
        rdata_d = rdata_q;
        if (accept && !err) begin
            dp_d   = 1'b1;
            wr_d   = Hwrite;
            idx_d  = rd_idx;
            strb_d = strb;
            if (!Hwrite) rdata_d = rd_word;
        end else if (ready) begin
            dp_d = 1'b0;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dp_q    <= 1'b0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            strb_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dp_q    <= dp_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            strb_q  <= strb_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[idx_q] <= wr_word;
        end
    end

    assign Hrdata     = rdata_q;
    assign Hready_out = ready;
    assign Hresp      = ((state_q == S_ERR1) || (state_q == S_ERR2))
                      ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: doc/ahb_uvc_slave_mem.md
# ahb_uvc_slave_mem

Parametrised AHB-Lite slave memory: the responder-side model that sits behind the AHB_UVC interface signals and answers master transfers with data, programmable wait states and two-cycle ERROR responses. It generalises the bare interface signal set to configurable address/data width and memory depth. It adds byte-lane writes, pipelined back-to-back transfers and an error region. It gives the VIP a synthesisable, self-checking target for driver and monitor bring-up.

## Interface
- ADDR_WIDTH, 32: Haddr width.
- DATA_WIDTH, 32: Hwdata/Hrdata width. Legal values are 32 and 64.
- MEM_DEPTH, 256: number of DATA_WIDTH-bit words. Must be a power of two.
- WAIT_STATES, 0: wait cycles inserted per NONSEQ/SEQ data phase. Range 0..7.
- ERR_BASE, 'h0000_F000 and ERR_MASK, 'hFFFF_F000: an address hits the error region when (Haddr & ERR_MASK) == ERR_BASE.
- hclk  in  1  clock. All logic is on the rising edge.
- hreset  in  1  asynchronous, active-high reset.
- Hsel  in  1  slave select.
- Haddr  in  ADDR_WIDTH  byte address.
- Htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- Hwrite  in  1  1 = write.
- Hsize  in  3  transfer size, log2 of the byte count.
- Hburst  in  3  burst type. Accepted but not checked.
- Hmastlock  in  1  ignored.
- Hprot  in  4  ignored.
- Hwdata  in  DATA_WIDTH  write data, valid in the data phase.
- Hready_in  in  1  bus ready.
- Hrdata  out  DATA_WIDTH  read data.
- Hready_out  out  1  slave ready.
- Hresp  out  1  0 = OKAY, 1 = ERROR.

## Operation
- **Address-phase capture.** An address phase is captured on a clock edge where Hsel=1, Hready_in=1 and Htrans[1]=1. The block registers addr, write, size and an err flag.
- **Error conditions.** err is set when any of the following holds:
  - the address hits the error region;
  - Hsize > log2(DATA_WIDTH/8);
  - Haddr is not aligned to Hsize;
  - the word index is at or beyond MEM_DEPTH.
- **IDLE, BUSY or Hsel=0.** These produce no transfer. The following data phase is OKAY with zero wait.
- **FSM states.** IDLE, WAIT, ERR1, ERR2.
  - IDLE to WAIT: valid capture, err=0, WAIT_STATES>0. The wait counter loads WAIT_STATES-1.
  - IDLE stays IDLE: valid capture, err=0, WAIT_STATES=0. The zero-wait data phase completes in the next cycle.
  - WAIT: Hready_out=0 and the counter decrements. At 0 the FSM moves to the final data cycle, where Hready_out=1.
  - Valid capture with err=1 (from IDLE or from the final data cycle): go to ERR1, where Hready_out=0 and Hresp=1. Then ERR2, where Hready_out=1 and Hresp=1. Then IDLE.
  - Wait states are not inserted before ERR1.
- **Writes.** A write commits on the final data cycle (Hready_out=1, Hresp=0). Only the byte lanes selected by Hsize and the low address bits take Hwdata. Other bytes are unchanged. Errored writes never modify memory.
- **Reads.** Hrdata is registered. It holds the full addressed word, all lanes, and is valid in the final data cycle. Outside read data phases, Hrdata holds its last value.
- **Forwarding.** A write data phase can complete in the same cycle as a read address phase to the same word. In that case the read returns the byte-merged new data.
- **Pipelining.** A new address phase is accepted during the final data cycle (Hready_out=1) of the previous transfer. Back-to-back zero-wait transfers sustain one transfer per cycle.

## Timing
- **Reset values:** Hready_out=1, Hresp=0, Hrdata=0, FSM=IDLE, counter=0. All memory words are 0.
- **Reset mid-transfer:** the in-flight transfer is abandoned, a pending write is not committed, and outputs return to their reset values immediately (asynchronous).
- **Read latency:** data appears WAIT_STATES+1 cycles after the address-phase edge.
- **Write latency:** the write is visible to a read issued in the cycle it completes.
- **Error response:** exactly 2 data-phase cycles, ERROR with Hready_out=0, then ERROR with Hready_out=1.
- **Master cancellation:** if the master drives IDLE during ERR2, no further transfer occurs.
- **Address wrap-around:** none. Out-of-range addresses take the error path.

## Structure
- **Shared package** ahb_uvc_pkg holds:
  - the htrans_e, hsize_e and hburst_e enums;
  - the HRESP_OKAY and HRESP_ERROR constants;
  - the slave FSM state typedef.
- **Sub-module** ahb_uvc_byte_lane_dec is combinational. It maps (Haddr low bits, Hsize) to a DATA_WIDTH/8 byte-strobe vector and an align_err flag. The slave instantiates it once and uses it for both the write mask and the error check.

## Test plan
- **Reset:** hreset=1 mid-WAIT -> Hready_out=1, Hresp=0 and Hrdata=0 on the same cycle. A read of 0x10 after release returns 0.
- **Zero-wait back-to-back:** WAIT_STATES=0. Write word 0x4=0xDEADBEEF, then read 0x4 in the next address phase -> Hrdata=0xDEADBEEF, Hready_out never low.
- **Byte lanes:** write halfword 0xABCD at 0x6 over 0x11223344 at word 0x4 -> a read returns 0xABCD3344.
- **Wait states:** WAIT_STATES=3, read -> Hready_out low for exactly 3 cycles, and data is valid on the 4th cycle after the address phase.
- **Errors:** each of the following gives ERROR, ERROR with Hready_out 0 then 1, and memory unchanged:
  - write to 0xF004;
  - word access at 0x2;
  - word index MEM_DEPTH.
- **BUSY/IDLE mid-burst:** INCR4 containing a BUSY -> the BUSY gets an OKAY zero-wait response. The 4 beats write consecutive words and return the correct read data.
